mips32_mem_responder: RTL

- Word-addressed data/instruction memory responder for the MIPS32 pipeline: the memory-side end of the load/store/fetch interface.
- Accepts one read or write request at a time over a valid/ready handshake.
- Inserts a programmable number of wait states, then returns a response (read data or write acknowledge) over a second valid/ready handshake.
- Sits between the pipeline's MEM/IF request logic and the storage array; replaces direct array indexing from the pipeline.

---
 rtl/mips32_pkg.sv | 43 ++++
 rtl/mips32_mem_responder_if.sv | 27 ++
 rtl/mips32_mem_array.sv | 41 ++++
 rtl/mips32_mem_responder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, instruction classes and the memory
// responder state encoding.
package mips32_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU = 3'd0,
    RM_ALU = 3'd1,
    LOAD   = 3'd2,
    STORE  = 3'd3,
    BRANCH = 3'd4,
    HALT   = 3'd5
  } instr_type_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rsp_state_t;

  // Any set bit above the index width means the word lies outside the array.
  function automatic logic addr_oob(input logic [WORD_W-1:0] addr,
                                    input int unsigned aw);
    return (addr >> aw) != '0;
  endfunction

endpackage

// File: rtl/mips32_mem_responder_if.sv
// Request/response bus between the pipeline (master) and the memory responder (slave).
// Both channels transfer on a rising edge where valid and ready are both high.
interface mips32_mem_responder_if;
  import mips32_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [WORD_W-1:0] rsp_rdata;
  logic              rsp_we;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_we, rsp_err
  );

endinterface

// File: rtl/mips32_mem_array.sv
// Single-port synchronous word RAM with a registered read port.
// Storage is never reset; only the read register is, so it can drive rsp_rdata directly.
module mips32_mem_array
  import mips32_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic              clr_i,
  input  logic [AW-1:0]     idx_i,
  input  logic [WORD_W-1:0] wdata_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      mem_q[idx_i] <= wdata_i;
    end
  end

  // Writes and rejected accesses return zero; otherwise the value holds.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rdata_q <= '0;
    end else if (clr_i || (en_i && we_i)) begin
      rdata_q <= '0;
    end else if (en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory-side end of the MIPS32 load/store/fetch bus: accepts one request,
// waits WAIT_CYC cycles, performs the access and holds the response until taken.
module mips32_mem_responder
  import mips32_pkg::*;
#(
  parameter int DEPTH    = 1024,
  parameter int AW       = 10,
  parameter int WAIT_CYC = 2
) (
  input  logic                   clk1,
  input  logic                   rst_n,
  mips32_mem_responder_if.slave  bus,
  output logic                   busy,
  output rsp_state_t             state_o
);

  rsp_state_t        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_we_q, rsp_we_d;
  logic              ram_en, ram_we, ram_clr;
  logic [WORD_W-1:0] ram_rdata;

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_we_q    <= rsp_we_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_we_d    = rsp_we_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_clr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          cnt_d   = 4'(WAIT_CYC);
          state_d = WAIT;
        end
      end
      WAIT: begin
        // WAIT_CYC == 0 still spends this one cycle, giving the 1-cycle response.
        if (cnt_q == '0) begin
          if (addr_oob(addr_q, AW)) begin
            ram_clr   = 1'b1;
            rsp_err_d = 1'b1;
          end else begin
            ram_en = 1'b1;
            ram_we = we_q;
          end
          rsp_valid_d = 1'b1;
          rsp_we_d    = we_q;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          rsp_err_d   = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  mips32_mem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk1),
    .rst_ni  (rst_n),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .clr_i   (ram_clr),
    .idx_i   (addr_q[AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (ram_rdata)
  );

  assign bus.req_ready = (state_q == IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = ram_rdata;
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_err   = rsp_err_q;
  assign busy          = (state_q != IDLE);
  assign state_o       = state_q;

endmodule
